// File: rtl/mem_stage.sv
// mem_stage
//   Memory stage of the pipeline. Takes the mem_* register written by the
//   address/execute stage. Loads and stores go out on a req/ready data-memory
//   port. Store data is replicated into byte lanes. Load data is aligned and
//   then sign- or zero-extended. The stage stalls upstream until the access
//   completes or times out, and then writes the wb_* register. Non-memory ops
//   pass mem_alu_result through with one cycle of latency.
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   mem_*            incoming pipeline register (held stable while mem_stall)
//   mem_stall        hold upstream
//   dmem_req/we/addr/wdata/be, dmem_ready/rdata   data-memory port
//   wb_*             outgoing pipeline register for writeback
// Parameters
//   TIMEOUT_CYCLES   max cycles dmem_req may stay unanswered (>=1)

`ifndef INST_OP_WIDTH
`define INST_OP_WIDTH      3
`define INST_OP_ALU        3'd0
`define INST_OP_LOAD       3'd1
`define INST_OP_STORE      3'd2
`endif
`ifndef DATA_SIZE_WIDTH
`define DATA_SIZE_WIDTH    2
`define DATA_SIZE_BYTE     2'd0
`define DATA_SIZE_HALF     2'd1
`define DATA_SIZE_WORD     2'd2
`endif
`ifndef EXTEND_TYPE_WIDTH
`define EXTEND_TYPE_WIDTH  1
`define EXTEND_ZERO        1'b0
`define EXTEND_SIGN        1'b1
`endif

module mem_stage #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mem_valid,
  input  logic [4:0]                    mem_drnum,
  input  logic [15:0]                   mem_addr,
  input  logic [31:0]                   mem_alu_result,
  input  logic                          mem_reg_we,
  input  logic [`INST_OP_WIDTH-1:0]     mem_inst_op,
  input  logic [`DATA_SIZE_WIDTH-1:0]   mem_data_size,
  input  logic [`EXTEND_TYPE_WIDTH-1:0] mem_extend_type,
  output logic                          mem_stall,
  output logic                          dmem_req,
  output logic                          dmem_we,
  output logic [15:0]                   dmem_addr,
  output logic [31:0]                   dmem_wdata,
  output logic [3:0]                    dmem_be,
  input  logic                          dmem_ready,
  input  logic [31:0]                   dmem_rdata,
  output logic                          wb_valid,
  output logic [4:0]                    wb_drnum,
  output logic [31:0]                   wb_data,
  output logic                          wb_reg_we,
  output logic                          wb_misaligned,
  output logic                          wb_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        is_load, is_store, ldst, aligned, access, abort, stall;
  logic [31:0] lane, load_data;

  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_drnum_q, wb_drnum_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_reg_we_q, wb_reg_we_d;
  logic        wb_misaligned_q, wb_misaligned_d;
  logic        wb_timeout_q, wb_timeout_d;

  assign is_load  = mem_valid && (mem_inst_op == `INST_OP_LOAD);
  assign is_store = mem_valid && (mem_inst_op == `INST_OP_STORE);
  assign ldst     = is_load || is_store;

  always_comb begin
    aligned = 1'b0;
    case (mem_data_size)
      `DATA_SIZE_BYTE: aligned = 1'b1;
      `DATA_SIZE_HALF: aligned = ~mem_addr[0];
      `DATA_SIZE_WORD: aligned = (mem_addr[1:0] == 2'b00);
      default:         aligned = 1'b0;
    endcase
  end

  assign access = ldst && aligned;
  // cnt_q is 0 in the first request cycle, so with TIMEOUT_CYCLES=1 the
  // first cycle already aborts.
  assign abort  = access && !dmem_ready && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign stall  = access && !dmem_ready && !abort;

  // Reset gates the handshake outputs combinationally, so an access that is
  // in flight disappears from the bus as soon as rst rises.
  assign dmem_req  = access && !rst;
  assign mem_stall = stall && !rst;

  // Address and data fields come straight from mem_*. Upstream holds mem_*
  // while stalled, so the fields stay stable until ready.
  assign dmem_we   = (mem_inst_op == `INST_OP_STORE);
  assign dmem_addr = {mem_addr[15:2], 2'b00};

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = mem_alu_result;
    if (dmem_we) begin
      case (mem_data_size)
        `DATA_SIZE_BYTE: begin
          dmem_be    = 4'b0001 << mem_addr[1:0];
          dmem_wdata = {4{mem_alu_result[7:0]}};
        end
        `DATA_SIZE_HALF: begin
          dmem_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
          dmem_wdata = {2{mem_alu_result[15:0]}};
        end
        default: begin
          dmem_be    = 4'b1111;
          dmem_wdata = mem_alu_result;
        end
      endcase
    end
  end

  assign lane = dmem_rdata >> {mem_addr[1:0], 3'b000};

  always_comb begin
    load_data = lane;
    case (mem_data_size)
      `DATA_SIZE_BYTE: load_data = (mem_extend_type == `EXTEND_SIGN) ?
                                   {{24{lane[7]}}, lane[7:0]} : {24'b0, lane[7:0]};
      `DATA_SIZE_HALF: load_data = (mem_extend_type == `EXTEND_SIGN) ?
                                   {{16{lane[15]}}, lane[15:0]} : {16'b0, lane[15:0]};
      default:         load_data = lane;
    endcase
  end

  // Request tracking. Leaving WAIT for any reason clears the count, so every
  // new access starts again at 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (stall) begin
          state_d = WAIT;
          cnt_d   = CW'(1);
        end
      end
      WAIT: begin
        if (!stall) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    wb_valid_d      = wb_valid_q;
    wb_drnum_d      = wb_drnum_q;
    wb_data_d       = wb_data_q;
    wb_reg_we_d     = wb_reg_we_q;
    wb_misaligned_d = wb_misaligned_q;
    wb_timeout_d    = wb_timeout_q;
    if (stall) begin
      // Send a bubble to writeback. The other fields hold.
      wb_valid_d  = 1'b0;
      wb_reg_we_d = 1'b0;
    end else begin
      wb_valid_d      = mem_valid;
      wb_drnum_d      = mem_drnum;
      wb_data_d       = is_load ? load_data : mem_alu_result;
      wb_reg_we_d     = mem_valid && mem_reg_we && !(ldst && !aligned) &&
                        !abort && (mem_drnum != 5'd0);
      wb_misaligned_d = ldst && !aligned;
      wb_timeout_d    = abort;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      wb_valid_q      <= 1'b0;
      wb_drnum_q      <= 5'd0;
      wb_data_q       <= 32'd0;
      wb_reg_we_q     <= 1'b0;
      wb_misaligned_q <= 1'b0;
      wb_timeout_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      wb_valid_q      <= wb_valid_d;
      wb_drnum_q      <= wb_drnum_d;
      wb_data_q       <= wb_data_d;
      wb_reg_we_q     <= wb_reg_we_d;
      wb_misaligned_q <= wb_misaligned_d;
      wb_timeout_q    <= wb_timeout_d;
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_drnum      = wb_drnum_q;
  assign wb_data       = wb_data_q;
  assign wb_reg_we     = wb_reg_we_q;
  assign wb_misaligned = wb_misaligned_q;
  assign wb_timeout    = wb_timeout_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage (TIMEOUT_CYCLES=4). Each vector has
// hand-computed expected values.

`ifndef INST_OP_WIDTH
`define INST_OP_WIDTH      3
`define INST_OP_ALU        3'd0
`define INST_OP_LOAD       3'd1
`define INST_OP_STORE      3'd2
`endif
`ifndef DATA_SIZE_WIDTH
`define DATA_SIZE_WIDTH    2
`define DATA_SIZE_BYTE     2'd0
`define DATA_SIZE_HALF     2'd1
`define DATA_SIZE_WORD     2'd2
`endif
`ifndef EXTEND_TYPE_WIDTH
`define EXTEND_TYPE_WIDTH  1
`define EXTEND_ZERO        1'b0
`define EXTEND_SIGN        1'b1
`endif

module tb_mem_stage;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          mem_valid;
  logic [4:0]                    mem_drnum;
  logic [15:0]                   mem_addr;
  logic [31:0]                   mem_alu_result;
  logic                          mem_reg_we;
  logic [`INST_OP_WIDTH-1:0]     mem_inst_op;
  logic [`DATA_SIZE_WIDTH-1:0]   mem_data_size;
  logic [`EXTEND_TYPE_WIDTH-1:0] mem_extend_type;
  logic                          mem_stall, dmem_req, dmem_we, dmem_ready;
  logic [15:0]                   dmem_addr;
  logic [31:0]                   dmem_wdata, dmem_rdata, wb_data;
  logic [3:0]                    dmem_be;
  logic                          wb_valid, wb_reg_we, wb_misaligned, wb_timeout;
  logic [4:0]                    wb_drnum;

  int n_vec = 0;
  int n_err = 0;

  mem_stage #(.TIMEOUT_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_drnum(mem_drnum), .mem_addr(mem_addr),
    .mem_alu_result(mem_alu_result), .mem_reg_we(mem_reg_we),
    .mem_inst_op(mem_inst_op), .mem_data_size(mem_data_size),
    .mem_extend_type(mem_extend_type), .mem_stall(mem_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_drnum(wb_drnum),
    .wb_data(wb_data), .wb_reg_we(wb_reg_we), .wb_misaligned(wb_misaligned),
    .wb_timeout(wb_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [1:0] sz, input logic ext,
                       input logic [15:0] addr, input logic [31:0] alu,
                       input logic [4:0] rd, input logic we,
                       input logic rdy, input logic [31:0] rdata);
    mem_valid       = 1'b1;
    mem_inst_op     = op;
    mem_data_size   = sz;
    mem_extend_type = ext;
    mem_addr        = addr;
    mem_alu_result  = alu;
    mem_drnum       = rd;
    mem_reg_we      = we;
    dmem_ready      = rdy;
    dmem_rdata      = rdata;
  endtask

  task automatic idle;
    mem_valid  = 1'b0;
    mem_inst_op = `INST_OP_ALU;
    dmem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    mem_drnum = 5'd0; mem_addr = 16'd0; mem_alu_result = 32'd0; mem_reg_we = 1'b0;
    mem_data_size = `DATA_SIZE_WORD; mem_extend_type = `EXTEND_ZERO; dmem_rdata = 32'd0;
    #1;
    chk("rst wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst wb_data", wb_data, 32'd0);
    chk("rst dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst mem_stall", {31'd0, mem_stall}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Sign-extended byte load, zero-wait.
    drive(`INST_OP_LOAD, `DATA_SIZE_BYTE, `EXTEND_SIGN, 16'h0103, 32'h0, 5'd5, 1'b1, 1'b1, 32'h80FF_1234);
    #1;
    chk("lb req", {31'd0, dmem_req}, 32'd1);
    chk("lb stall", {31'd0, mem_stall}, 32'd0);
    chk("lb addr", {16'd0, dmem_addr}, 32'h0100);
    chk("lb be", {28'd0, dmem_be}, 32'hF);
    chk("lb we", {31'd0, dmem_we}, 32'd0);
    tick();
    chk("lb wb_data", wb_data, 32'hFFFF_FF80);
    chk("lb wb_reg_we", {31'd0, wb_reg_we}, 32'd1);
    chk("lb wb_drnum", {27'd0, wb_drnum}, 32'd5);
    chk("lb wb_valid", {31'd0, wb_valid}, 32'd1);

    drive(`INST_OP_LOAD, `DATA_SIZE_BYTE, `EXTEND_ZERO, 16'h0103, 32'h0, 5'd5, 1'b1, 1'b1, 32'h80FF_1234);
    tick();
    chk("lbu wb_data", wb_data, 32'h0000_0080);
    drive(`INST_OP_LOAD, `DATA_SIZE_HALF, `EXTEND_SIGN, 16'h0102, 32'h0, 5'd6, 1'b1, 1'b1, 32'h80FF_1234);
    tick();
    chk("lh wb_data", wb_data, 32'hFFFF_80FF);
    drive(`INST_OP_LOAD, `DATA_SIZE_HALF, `EXTEND_ZERO, 16'h0100, 32'h0, 5'd6, 1'b1, 1'b1, 32'h80FF_9234);
    tick();
    chk("lhu wb_data", wb_data, 32'h0000_9234);

    // Stores.
    drive(`INST_OP_STORE, `DATA_SIZE_HALF, `EXTEND_ZERO, 16'h0042, 32'h0000_BEEF, 5'd0, 1'b0, 1'b1, 32'h0);
    #1;
    chk("sh be", {28'd0, dmem_be}, 32'hC);
    chk("sh wdata", dmem_wdata, 32'hBEEF_BEEF);
    chk("sh addr", {16'd0, dmem_addr}, 32'h0040);
    chk("sh we", {31'd0, dmem_we}, 32'd1);
    tick();
    chk("sh wb_reg_we", {31'd0, wb_reg_we}, 32'd0);
    chk("sh wb_data", wb_data, 32'h0000_BEEF);
    drive(`INST_OP_STORE, `DATA_SIZE_BYTE, `EXTEND_ZERO, 16'h0041, 32'h1234_5678, 5'd0, 1'b0, 1'b1, 32'h0);
    #1;
    chk("sb be", {28'd0, dmem_be}, 32'h2);
    chk("sb wdata", dmem_wdata, 32'h7878_7878);
    tick();

    // Word load answered in the 4th request cycle (cnt==TIMEOUT-1 but ready).
    drive(`INST_OP_LOAD, `DATA_SIZE_WORD, `EXTEND_ZERO, 16'h0010, 32'h0, 5'd7, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lw wait stall", {31'd0, mem_stall}, 32'd1);
      tick();
      chk("lw wait wb_valid", {31'd0, wb_valid}, 32'd0);
    end
    dmem_ready = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    #1;
    chk("lw ready stall", {31'd0, mem_stall}, 32'd0);
    tick();
    chk("lw wb_data", wb_data, 32'hCAFE_F00D);
    chk("lw wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("lw wb_timeout", {31'd0, wb_timeout}, 32'd0);

    // Misaligned word load.
    drive(`INST_OP_LOAD, `DATA_SIZE_WORD, `EXTEND_ZERO, 16'h0002, 32'h0, 5'd7, 1'b1, 1'b0, 32'h0);
    #1;
    chk("mis req", {31'd0, dmem_req}, 32'd0);
    chk("mis stall", {31'd0, mem_stall}, 32'd0);
    tick();
    chk("mis wb_misaligned", {31'd0, wb_misaligned}, 32'd1);
    chk("mis wb_reg_we", {31'd0, wb_reg_we}, 32'd0);

    // Timeout: ready never comes.
    drive(`INST_OP_LOAD, `DATA_SIZE_WORD, `EXTEND_ZERO, 16'h0020, 32'h0, 5'd8, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to req", {31'd0, dmem_req}, 32'd1);
      chk("to stall", {31'd0, mem_stall}, (i < 3) ? 32'd1 : 32'd0);
      tick();
      if (i < 3) chk("to bubble", {31'd0, wb_valid}, 32'd0);
    end
    chk("to wb_timeout", {31'd0, wb_timeout}, 32'd1);
    chk("to wb_reg_we", {31'd0, wb_reg_we}, 32'd0);
    chk("to wb_valid", {31'd0, wb_valid}, 32'd1);
    idle();
    #1;
    chk("to idle req", {31'd0, dmem_req}, 32'd0);
    tick();

    // ALU pass-through; ready while no request is ignored.
    drive(`INST_OP_ALU, `DATA_SIZE_WORD, `EXTEND_ZERO, 16'h0001, 32'h1122_3344, 5'd0, 1'b1, 1'b1, 32'h0);
    tick();
    chk("alu r0 wb_reg_we", {31'd0, wb_reg_we}, 32'd0);
    drive(`INST_OP_ALU, `DATA_SIZE_WORD, `EXTEND_ZERO, 16'h0001, 32'h1122_3344, 5'd3, 1'b1, 1'b1, 32'h0);
    #1;
    chk("alu req", {31'd0, dmem_req}, 32'd0);
    tick();
    chk("alu wb_data", wb_data, 32'h1122_3344);
    chk("alu wb_reg_we", {31'd0, wb_reg_we}, 32'd1);

    // Reset during the 2nd WAIT cycle.
    drive(`INST_OP_LOAD, `DATA_SIZE_WORD, `EXTEND_ZERO, 16'h0030, 32'h0, 5'd9, 1'b1, 1'b0, 32'h0);
    tick();
    #1;
    chk("rw stall", {31'd0, mem_stall}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rw req", {31'd0, dmem_req}, 32'd0);
    chk("rw stall0", {31'd0, mem_stall}, 32'd0);
    chk("rw wb_drnum", {27'd0, wb_drnum}, 32'd0);
    chk("rw wb_data", wb_data, 32'd0);
    tick();
    rst = 1'b0;
    // The count restarts from 0, so three wait cycles still stall.
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rw2 stall", {31'd0, mem_stall}, 32'd1);
      tick();
    end
    dmem_ready = 1'b1; dmem_rdata = 32'h0102_0304;
    tick();
    chk("rw2 wb_data", wb_data, 32'h0102_0304);
    chk("rw2 wb_reg_we", {31'd0, wb_reg_we}, 32'd1);
    chk("rw2 wb_timeout", {31'd0, wb_timeout}, 32'd0);
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
